// File: rtl/id_issue_ctrl.sv
// Decode-to-EX issue stage: one registered output entry plus a per-register in-flight writer scoreboard.
// Optional `ID_FORWARD_EN: read hazards reduce to load-use against the held entry (EX forwarding assumed).
module id_issue_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int PAYLOAD_W  = 128,
    parameter int CNT_W      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_WIDTH-1:0] in_rs1_i,
    input  logic [ADDR_WIDTH-1:0] in_rs2_i,
    input  logic                  in_use_rs1_i,
    input  logic                  in_use_rs2_i,
    input  logic [ADDR_WIDTH-1:0] in_rd_i,
    input  logic                  in_we_i,
    input  logic                  in_load_i,
    input  logic [PAYLOAD_W-1:0]  in_payload_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_rd_o,
    output logic                  out_we_o,
    output logic                  out_load_o,
    output logic [PAYLOAD_W-1:0]  out_payload_o,
    input  logic                  flush_i,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_i,
    output logic                  stall_o,
    output logic                  busy_o
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]      cnt_q [NREG];
    logic [CNT_W-1:0]      cnt_d [NREG];
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic                  out_we_q, out_we_d;
    logic                  out_load_q, out_load_d;
    logic [PAYLOAD_W-1:0]  out_payload_q, out_payload_d;

    logic read_hazard, sat_hazard, hazard, in_ready, accept, flush_undo, busy;

    // Net counter update: at most +1 and up to -2 per cycle, floored at zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc,
                                                  input logic dec_wb, input logic dec_fl);
        logic [CNT_W+1:0] up;
        logic [CNT_W+1:0] down;
        up   = {2'b00, cnt} + (CNT_W + 2)'(inc);
        down = (CNT_W + 2)'(dec_wb) + (CNT_W + 2)'(dec_fl);
        return (up > down) ? CNT_W'(up - down) : '0;
    endfunction

    // Blocks a writer whose counter could otherwise wrap.
    assign sat_hazard = in_we_i && (in_rd_i != '0) && (cnt_q[in_rd_i] == CNT_MAX);

`ifdef ID_FORWARD_EN
    assign read_hazard = out_valid_q && out_load_q && (out_rd_q != '0) &&
                         ((in_use_rs1_i && (in_rs1_i == out_rd_q)) ||
                          (in_use_rs2_i && (in_rs2_i == out_rd_q)));
`else
    assign read_hazard = (in_use_rs1_i && (in_rs1_i != '0) && (cnt_q[in_rs1_i] != '0)) ||
                         (in_use_rs2_i && (in_rs2_i != '0) && (cnt_q[in_rs2_i] != '0));
`endif

    assign hazard   = read_hazard || sat_hazard;
    assign in_ready = !hazard && !flush_i && (!out_valid_q || out_ready_i);
    assign accept   = in_valid_i && in_ready;

    // A flushed writer that EX never took will never write back, so its count is returned here.
    assign flush_undo = flush_i && out_valid_q && out_we_q && (out_rd_q != '0) && !out_ready_i;

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_d[i] = cnt_next(cnt_q[i],
                                accept && in_we_i && (in_rd_i == ADDR_WIDTH'(i)),
                                wb_valid_i && (wb_rd_i == ADDR_WIDTH'(i)),
                                flush_undo && (out_rd_q == ADDR_WIDTH'(i)));
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            busy = busy || (cnt_q[i] != '0);
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_rd_d      = out_rd_q;
        out_we_d      = out_we_q;
        out_load_d    = out_load_q;
        out_payload_d = out_payload_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_rd_d      = in_rd_i;
            out_we_d      = in_we_i;
            out_load_d    = in_load_i;
            out_payload_d = in_payload_i;
        end else if (out_ready_i || flush_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q   <= 1'b0;
            out_rd_q      <= '0;
            out_we_q      <= 1'b0;
            out_load_q    <= 1'b0;
            out_payload_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_we_q      <= out_we_d;
            out_load_q    <= out_load_d;
            out_payload_q <= out_payload_d;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in_ready_o    = in_ready;
    assign out_valid_o   = out_valid_q;
    assign out_rd_o      = out_rd_q;
    assign out_we_o      = out_we_q;
    assign out_load_o    = out_load_q;
    assign out_payload_o = out_payload_q;
    assign stall_o       = in_valid_i && hazard;
    assign busy_o        = busy;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl (default parameters); inputs change on the falling edge,
// combinational outputs are checked 1 time unit later, registered outputs at the following falling edge.
module tb_id_issue_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [4:0]   in_rs1_i, in_rs2_i, in_rd_i;
    logic         in_use_rs1_i, in_use_rs2_i, in_we_i, in_load_i;
    logic [127:0] in_payload_i;
    logic         out_valid_o, out_ready_i, out_we_o, out_load_o;
    logic [4:0]   out_rd_o;
    logic [127:0] out_payload_o;
    logic         flush_i, wb_valid_i;
    logic [4:0]   wb_rd_i;
    logic         stall_o, busy_o;

    int checks = 0;
    int failures = 0;

    id_issue_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .in_use_rs1_i(in_use_rs1_i), .in_use_rs2_i(in_use_rs2_i),
        .in_rd_i(in_rd_i), .in_we_i(in_we_i), .in_load_i(in_load_i),
        .in_payload_i(in_payload_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_rd_o(out_rd_o), .out_we_o(out_we_o), .out_load_o(out_load_o),
        .out_payload_o(out_payload_o),
        .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .stall_o(stall_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        in_valid_i = 1'b0; in_rs1_i = '0; in_rs2_i = '0; in_rd_i = '0;
        in_use_rs1_i = 1'b0; in_use_rs2_i = 1'b0; in_we_i = 1'b0; in_load_i = 1'b0;
        in_payload_i = '0; out_ready_i = 1'b1; flush_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0;
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic we, input logic ld,
                             input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [127:0] pl);
        in_valid_i = 1'b1; in_rd_i = rd; in_we_i = we; in_load_i = ld;
        in_rs1_i = rs1; in_use_rs1_i = u1; in_rs2_i = rs2; in_use_rs2_i = u2; in_payload_i = pl;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        repeat (2) @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", out_valid_o); end
        checks++; if (out_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", out_we_o); end
        checks++; if (out_load_o !== 1'b0) begin failures++; $display("FAIL rst_load got=%0b exp=0", out_load_o); end
        checks++; if (out_rd_o !== 5'd0) begin failures++; $display("FAIL rst_rd got=%0d exp=0", out_rd_o); end
        checks++; if (out_payload_o !== 128'd0) begin failures++; $display("FAIL rst_payload got=%0h exp=0", out_payload_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (i > 0) begin
                checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, out_valid_o); end
                checks++; if (out_payload_o !== 128'(100 + i - 1)) begin failures++; $display("FAIL b2b_payload[%0d] got=%0d exp=%0d", i, out_payload_o, 100 + i - 1); end
            end
            set_instr(5'(i + 1), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'(100 + i));
            #1;
            checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, in_ready_o); end
        end
        @(negedge clk_i);
        checks++; if (out_payload_o !== 128'd103) begin failures++; $display("FAIL b2b_last got=%0d exp=103", out_payload_o); end
        idle();
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid_o); end
    endtask

`ifndef ID_FORWARD_EN
    task automatic test_raw_stall();
        @(negedge clk_i);
        set_instr(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h50);
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL raw_wr_ready got=%0b exp=1", in_ready_o); end
        @(negedge clk_i);
        checks++; if (out_rd_o !== 5'd5 || out_we_o !== 1'b1) begin failures++; $display("FAIL raw_wr_out got=rd%0d/we%0b exp=rd5/we1", out_rd_o, out_we_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL raw_busy got=%0b exp=1", busy_o); end
        set_instr(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 128'h51);
        #1;
        checks++; if (stall_o !== 1'b1 || in_ready_o !== 1'b0) begin failures++; $display("FAIL raw_stall0 got=stall%0b/rdy%0b exp=stall1/rdy0", stall_o, in_ready_o); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL raw_empty[%0d] got=%0b exp=0", k, out_valid_o); end
            checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL raw_stall[%0d] got=%0b exp=1", k, stall_o); end
        end
        @(negedge clk_i);
        wb_valid_i = 1'b1; wb_rd_i = 5'd5;
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL raw_stall_wb got=%0b exp=1", stall_o); end
        @(negedge clk_i);
        wb_valid_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL raw_release got=stall%0b/rdy%0b exp=stall0/rdy1", stall_o, in_ready_o); end
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b1 || out_payload_o !== 128'h51) begin failures++; $display("FAIL raw_issue got=v%0b/%0h exp=v1/51", out_valid_o, out_payload_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL raw_busy_end got=%0b exp=0", busy_o); end
        idle();
    endtask
`else
    task automatic test_forward();
        @(negedge clk_i);
        out_ready_i = 1'b0;
        set_instr(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 128'h70);
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b1 || out_load_o !== 1'b1) begin failures++; $display("FAIL fwd_load_held got=v%0b/l%0b exp=v1/l1", out_valid_o, out_load_o); end
        set_instr(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 128'h71);
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL fwd_lu_stall0 got=%0b exp=1", stall_o); end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b1 || in_ready_o !== 1'b0) begin failures++; $display("FAIL fwd_lu_stall1 got=stall%0b/rdy%0b exp=stall1/rdy0", stall_o, in_ready_o); end
        @(negedge clk_i);
        #1;
        checks++; if (stall_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL fwd_lu_release got=stall%0b/rdy%0b exp=stall0/rdy1", stall_o, in_ready_o); end
        @(negedge clk_i);
        checks++; if (out_payload_o !== 128'h71) begin failures++; $display("FAIL fwd_reader_issue got=%0h exp=71", out_payload_o); end
        set_instr(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h72);
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL fwd_alu_ready got=%0b exp=1", in_ready_o); end
        @(negedge clk_i);
        set_instr(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 128'h73);
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL fwd_alu_nostall got=%0b exp=0", stall_o); end
        @(negedge clk_i);
        checks++; if (out_payload_o !== 128'h73) begin failures++; $display("FAIL fwd_alu_reader got=%0h exp=73", out_payload_o); end
        idle();
        wb_valid_i = 1'b1; wb_rd_i = 5'd7;
        repeat (2) @(negedge clk_i);
        wb_valid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL fwd_busy_end got=%0b exp=0", busy_o); end
    endtask
`endif

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            set_instr(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'(8'h30 + k));
            #1;
            checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL sat_wr_ready[%0d] got=%0b exp=1", k, in_ready_o); end
        end
        @(negedge clk_i);
        set_instr(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h33);
        #1;
        checks++; if (stall_o !== 1'b1 || in_ready_o !== 1'b0) begin failures++; $display("FAIL sat_stall got=stall%0b/rdy%0b exp=stall1/rdy0", stall_o, in_ready_o); end
        @(negedge clk_i);
        wb_valid_i = 1'b1; wb_rd_i = 5'd3;
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL sat_stall_wb got=%0b exp=1", stall_o); end
        @(negedge clk_i);
        wb_valid_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL sat_release got=%0b exp=1", in_ready_o); end
        @(negedge clk_i);
        checks++; if (out_payload_o !== 128'h33) begin failures++; $display("FAIL sat_issue got=%0h exp=33", out_payload_o); end
        idle();
        wb_valid_i = 1'b1; wb_rd_i = 5'd3;
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL sat_drained got=%0b exp=0", busy_o); end
        @(negedge clk_i);
        wb_valid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL sat_no_underflow got=%0b exp=0", busy_o); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            set_instr(5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 128'(8'hA0 + k));
            #1;
            checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL x0_ready[%0d] got=%0b exp=1", k, in_ready_o); end
        end
        @(negedge clk_i);
        idle();
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL x0_busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_flush();
        @(negedge clk_i);
        out_ready_i = 1'b0;
        set_instr(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h90);
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b1 || out_rd_o !== 5'd9) begin failures++; $display("FAIL fl_held got=v%0b/rd%0d exp=v1/rd9", out_valid_o, out_rd_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL fl_busy got=%0b exp=1", busy_o); end
        set_instr(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h91);
        #1;
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL fl_backpressure got=%0b exp=0", in_ready_o); end
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b1 || out_payload_o !== 128'h90) begin failures++; $display("FAIL fl_hold got=v%0b/%0h exp=v1/90", out_valid_o, out_payload_o); end
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        out_ready_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL fl_block got=%0b exp=0", in_ready_o); end
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL fl_undo got=v%0b/busy%0b exp=v0/busy0", out_valid_o, busy_o); end
        idle();
        // Counter at 2 (one consumed, one held), flush plus wb of the same register nets to zero.
        @(negedge clk_i);
        set_instr(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h92);
        @(negedge clk_i);
        set_instr(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h93);
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL fl_second_wr got=%0b exp=1", in_ready_o); end
        @(negedge clk_i);
        idle();
        out_ready_i = 1'b0; flush_i = 1'b1; wb_valid_i = 1'b1; wb_rd_i = 5'd9;
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL fl_net2 got=v%0b/busy%0b exp=v0/busy0", out_valid_o, busy_o); end
        idle();
        // Flush while EX accepts: entry counts as issued, writer stays tracked.
        @(negedge clk_i);
        set_instr(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h94);
        @(negedge clk_i);
        idle();
        flush_i = 1'b1;
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL fl_consumed got=v%0b/busy%0b exp=v0/busy1", out_valid_o, busy_o); end
        idle();
        wb_valid_i = 1'b1; wb_rd_i = 5'd9;
        @(negedge clk_i);
        wb_valid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL fl_consumed_wb got=%0b exp=0", busy_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        out_ready_i = 1'b0;
        set_instr(5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 128'h40);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("FAIL rm_pre got=v%0b/busy%0b exp=v1/busy1", out_valid_o, busy_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || out_we_o !== 1'b0 || out_load_o !== 1'b0) begin failures++; $display("FAIL rm_flags got=v%0b/we%0b/l%0b exp=0/0/0", out_valid_o, out_we_o, out_load_o); end
        checks++; if (out_rd_o !== 5'd0 || out_payload_o !== 128'd0) begin failures++; $display("FAIL rm_data got=rd%0d/%0h exp=0/0", out_rd_o, out_payload_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b exp=0", busy_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
        wb_valid_i = 1'b1; wb_rd_i = 5'd4;
        @(negedge clk_i);
        idle();
        checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin failures++; $display("FAIL rm_wb_after got=busy%0b/v%0b exp=0/0", busy_o, out_valid_o); end
        set_instr(5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'h60);
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rm_accept_ready got=%0b exp=1", in_ready_o); end
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b1 || out_payload_o !== 128'h60) begin failures++; $display("FAIL rm_accept got=v%0b/%0h exp=v1/60", out_valid_o, out_payload_o); end
        idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
`ifndef ID_FORWARD_EN
        test_raw_stall();
`else
        test_forward();
`endif
        test_saturation();
        test_flush();
        test_reset_mid();
        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
